// File: rtl/length_generation_nlane.sv
// C-Pack length generator: classifies LANES words per beat, emits per-lane code lengths and line bit offsets.
// Optional LENGTH_STATS_EN adds saturating line / incompressible-line counters.
module length_generation_nlane #(
  parameter int CACHE_LINE = 128,
  parameter int WORD_SIZE  = 32,
  parameter int LANES      = 2,
  parameter int DICT_IDX_W = 4,
  localparam int BEATS = CACHE_LINE / (WORD_SIZE * LANES),
  localparam int LEN_W = $clog2(WORD_SIZE + 3),
  localparam int ACC_W = $clog2((CACHE_LINE / WORD_SIZE) * (WORD_SIZE + 2) + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [LANES-1:0]       i_zero_full,
  input  logic [LANES-1:0]       i_zero_upper,
  input  logic [LANES-1:0]       i_match_full,
  input  logic [LANES-1:0]       i_match_3b,
  input  logic [LANES-1:0]       i_match_2b,
  input  logic                   i_flush,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [3*LANES-1:0]     o_encoded,
  output logic [LEN_W*LANES-1:0] o_length,
  output logic [ACC_W*LANES-1:0] o_offset,
  output logic [ACC_W-1:0]       o_beat_len,
  output logic                   o_line_end,
  output logic [ACC_W-1:0]       o_line_len,
  output logic                   o_incompressible,
  output logic [31:0]            o_stat_lines,
  output logic [31:0]            o_stat_incomp
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [ACC_W-1:0] LINE_BITS = ACC_W'(CACHE_LINE);

  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   valid_q;
  logic [3*LANES-1:0]     enc_q, enc_d;
  logic [LEN_W*LANES-1:0] len_q, len_d;
  logic [ACC_W*LANES-1:0] off_q, off_d;
  logic [ACC_W-1:0]       beat_len_q, beat_len_d;
  logic                   line_end_q, line_end_d;
  logic [ACC_W-1:0]       line_len_q, line_len_d;
  logic                   incomp_q, incomp_d;
  logic [ACC_W-1:0]       run_sum;
  logic                   accept, load;

  assign o_ready = ~valid_q | i_ready;
  assign accept  = i_valid & o_ready;
  assign load    = accept & ~i_flush;

  // Priority classification, then offsets as a running sum from the line accumulator.
  always_comb begin
    enc_d   = '0;
    len_d   = '0;
    off_d   = '0;
    run_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      if (i_zero_full[k]) begin
        enc_d[3*k +: 3]     = 3'd0;
        len_d[LEN_W*k +: LEN_W] = LEN_W'(2);
      end else if (i_match_full[k]) begin
        enc_d[3*k +: 3]     = 3'd1;
        len_d[LEN_W*k +: LEN_W] = LEN_W'(2 + DICT_IDX_W);
      end else if (i_zero_upper[k]) begin
        enc_d[3*k +: 3]     = 3'd2;
        len_d[LEN_W*k +: LEN_W] = LEN_W'(12);
      end else if (i_match_3b[k]) begin
        enc_d[3*k +: 3]     = 3'd4;
        len_d[LEN_W*k +: LEN_W] = LEN_W'(12 + DICT_IDX_W);
      end else if (i_match_2b[k]) begin
        enc_d[3*k +: 3]     = 3'd3;
        len_d[LEN_W*k +: LEN_W] = LEN_W'(4 + DICT_IDX_W + WORD_SIZE / 2);
      end else begin
        enc_d[3*k +: 3]     = 3'd5;
        len_d[LEN_W*k +: LEN_W] = LEN_W'(2 + WORD_SIZE);
      end
      off_d[ACC_W*k +: ACC_W] = acc_q + run_sum;
      run_sum = run_sum + ACC_W'(len_d[LEN_W*k +: LEN_W]);
    end
    beat_len_d = run_sum;
    line_len_d = acc_q + run_sum;
    line_end_d = (cnt_q == LAST_BEAT);
    incomp_d   = (line_len_d >= LINE_BITS);
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (i_flush) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      if (line_end_d) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = line_len_d;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q    <= 1'b0;
      enc_q      <= '0;
      len_q      <= '0;
      off_q      <= '0;
      beat_len_q <= '0;
      line_end_q <= 1'b0;
      line_len_q <= '0;
      incomp_q   <= 1'b0;
    end else if (load) begin
      valid_q    <= 1'b1;
      enc_q      <= enc_d;
      len_q      <= len_d;
      off_q      <= off_d;
      beat_len_q <= beat_len_d;
      line_end_q <= line_end_d;
      line_len_q <= line_len_d;
      incomp_q   <= incomp_d;
    end else if (i_ready) begin
      valid_q    <= 1'b0;
    end
  end

  assign o_valid          = valid_q;
  assign o_encoded        = enc_q;
  assign o_length         = len_q;
  assign o_offset         = off_q;
  assign o_beat_len       = beat_len_q;
  assign o_line_end       = line_end_q;
  assign o_line_len       = line_len_q;
  assign o_incompressible = incomp_q;

`ifdef LENGTH_STATS_EN
  logic [31:0] stat_lines_q, stat_incomp_q;
  logic        line_hs;

  assign line_hs = valid_q & i_ready & line_end_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stat_lines_q  <= '0;
      stat_incomp_q <= '0;
    end else begin
      if (line_hs && stat_lines_q != 32'hFFFF_FFFF)
        stat_lines_q <= stat_lines_q + 32'd1;
      if (line_hs && incomp_q && stat_incomp_q != 32'hFFFF_FFFF)
        stat_incomp_q <= stat_incomp_q + 32'd1;
    end
  end

  assign o_stat_lines  = stat_lines_q;
  assign o_stat_incomp = stat_incomp_q;
`else
  assign o_stat_lines  = '0;
  assign o_stat_incomp = '0;
`endif

endmodule

// File: tb/tb_length_generation_nlane.sv
// Bench for length_generation_nlane: directed vector table, handshake corner sequences and a randomized run against a reference model.
module tb_length_generation_nlane;
  localparam int CL    = 128;
  localparam int W     = 32;
  localparam int L     = 2;
  localparam int D     = 4;
  localparam int BEATS = CL / (W * L);
  localparam int LEN_W = $clog2(W + 3);
  localparam int ACC_W = $clog2((CL / W) * (W + 2) + 1);
`ifdef LENGTH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic i_valid, o_ready, i_flush, o_valid, i_ready;
  logic [L-1:0] zf, zu, mf, m3, m2;
  logic [3*L-1:0]     o_encoded;
  logic [LEN_W*L-1:0] o_length;
  logic [ACC_W*L-1:0] o_offset;
  logic [ACC_W-1:0]   o_beat_len, o_line_len;
  logic               o_line_end, o_incompressible;
  logic [31:0]        o_stat_lines, o_stat_incomp;

  always #5 clk = ~clk;

  length_generation_nlane #(.CACHE_LINE(CL), .WORD_SIZE(W), .LANES(L), .DICT_IDX_W(D)) dut (
    .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_zero_full(zf), .i_zero_upper(zu), .i_match_full(mf), .i_match_3b(m3), .i_match_2b(m2),
    .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
    .o_encoded(o_encoded), .o_length(o_length), .o_offset(o_offset), .o_beat_len(o_beat_len),
    .o_line_end(o_line_end), .o_line_len(o_line_len), .o_incompressible(o_incompressible),
    .o_stat_lines(o_stat_lines), .o_stat_incomp(o_stat_incomp)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected registered output beat plus line position as plain integers.
  bit     m_valid, m_end, m_inc;
  int     m_enc[L], m_len[L], m_off[L];
  int     m_beat, m_line, m_acc, m_cnt;
  longint m_lines, m_incomp;

  function automatic int code_enc(bit z, bit f, bit u, bit t, bit h);
    if (z) return 0;
    if (f) return 1;
    if (u) return 2;
    if (t) return 4;
    if (h) return 3;
    return 5;
  endfunction

  function automatic int code_len(int enc);
    case (enc)
      0: return 2;
      1: return 2 + D;
      2: return 12;
      4: return 12 + D;
      3: return 4 + D + W / 2;
      default: return 2 + W;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_end = 0; m_inc = 0; m_beat = 0; m_line = 0;
    m_acc = 0; m_cnt = 0; m_lines = 0; m_incomp = 0;
    for (int k = 0; k < L; k++) begin m_enc[k] = 0; m_len[k] = 0; m_off[k] = 0; end
  endtask

  task automatic check_model();
    chk("o_valid", o_valid, m_valid);
    chk("o_ready", o_ready, !m_valid || i_ready);
    if (m_valid) begin
      for (int k = 0; k < L; k++) begin
        chk($sformatf("enc%0d", k), o_encoded[3*k +: 3], m_enc[k]);
        chk($sformatf("len%0d", k), o_length[LEN_W*k +: LEN_W], m_len[k]);
        chk($sformatf("off%0d", k), o_offset[ACC_W*k +: ACC_W], m_off[k]);
      end
      chk("beat_len", o_beat_len, m_beat);
      chk("line_end", o_line_end, m_end);
      if (m_end) begin
        chk("line_len", o_line_len, m_line);
        chk("incomp", o_incompressible, m_inc);
      end
    end
    chk("stat_lines", o_stat_lines, STATS ? m_lines : 0);
    chk("stat_incomp", o_stat_incomp, STATS ? m_incomp : 0);
  endtask

  // One clock: check current outputs, advance the model with current inputs, cross the edge.
  task automatic step();
    bit rdy, acc_b;
    int sum;
    #1;
    check_model();
    rdy   = !m_valid || i_ready;
    acc_b = i_valid && rdy;
    if (m_valid && i_ready && m_end) begin
      m_lines++;
      if (m_inc) m_incomp++;
    end
    if (acc_b && !i_flush) begin
      sum = 0;
      for (int k = 0; k < L; k++) begin
        m_enc[k] = code_enc(zf[k], mf[k], zu[k], m3[k], m2[k]);
        m_len[k] = code_len(m_enc[k]);
        m_off[k] = m_acc + sum;
        sum += m_len[k];
      end
      m_beat = sum; m_end = (m_cnt == BEATS - 1); m_line = m_acc + sum;
      m_inc = (m_line >= CL); m_valid = 1;
      if (m_end) begin m_acc = 0; m_cnt = 0; end
      else begin m_acc += sum; m_cnt++; end
    end else begin
      if (i_ready) m_valid = 0;
      if (i_flush) begin m_acc = 0; m_cnt = 0; end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [L-1:0] a_zf, a_mf, a_zu, a_m3, a_m2,
                       input bit fl, input bit rd);
    i_valid = v; zf = a_zf; mf = a_mf; zu = a_zu; m3 = a_m3; m2 = a_m2;
    i_flush = fl; i_ready = rd;
  endtask

  typedef struct {
    logic [L-1:0] zf, mf, zu, m3, m2;
    int enc0, enc1, len0, len1, off0, off1, beat;
    bit last;
    int line;
    bit inc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2,  2,  0,   2,  4, 1'b0,   0, 1'b0};
    tbl[1] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0,  2,  2,  4,   6,  4, 1'b1,   8, 1'b0};
    tbl[2] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5, 5, 34, 34,  0,  34, 68, 1'b0,   0, 1'b0};
    tbl[3] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 5, 5, 34, 34, 68, 102, 68, 1'b1, 136, 1'b1};
    tbl[4] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 0, 3,  2, 24,  0,   2, 26, 1'b0,   0, 1'b0};
    tbl[5] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2, 4, 12, 16, 26,  38, 28, 1'b1,  54, 1'b0};
    tbl[6] = '{2'b00, 2'b11, 2'b00, 2'b00, 2'b00, 1, 1,  6,  6,  0,   6, 12, 1'b0,   0, 1'b0};
    tbl[7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b11, 4, 3, 16, 24, 12,  28, 40, 1'b1,  52, 1'b0};

    rst = 1'b1;
    drive(0, '0, '0, '0, '0, '0, 0, 1);
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_enc", o_encoded, 0);
    chk("rst_len", o_length, 0);
    chk("rst_off", o_offset, 0);
    chk("rst_line", {o_beat_len, o_line_len, o_line_end, o_incompressible}, 0);
    chk("rst_stats", {o_stat_lines, o_stat_incomp}, 0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      drive(1, tbl[i].zf, tbl[i].mf, tbl[i].zu, tbl[i].m3, tbl[i].m2, 0, 1);
      step();
      chk($sformatf("tbl%0d_enc", i), o_encoded, {3'(tbl[i].enc1), 3'(tbl[i].enc0)});
      chk($sformatf("tbl%0d_len", i), o_length, {LEN_W'(tbl[i].len1), LEN_W'(tbl[i].len0)});
      chk($sformatf("tbl%0d_off", i), o_offset, {ACC_W'(tbl[i].off1), ACC_W'(tbl[i].off0)});
      chk($sformatf("tbl%0d_beat", i), o_beat_len, tbl[i].beat);
      chk($sformatf("tbl%0d_end", i), o_line_end, tbl[i].last);
      if (tbl[i].last) begin
        chk($sformatf("tbl%0d_line", i), o_line_len, tbl[i].line);
        chk($sformatf("tbl%0d_inc", i), o_incompressible, tbl[i].inc);
      end
    end
    drive(0, '0, '0, '0, '0, '0, 0, 1);
    step();

    // Backpressure: beat A registered, beat B waits while i_ready is low.
    drive(1, 2'b11, '0, '0, '0, '0, 0, 1);
    step();
    drive(1, 2'b00, '0, '0, '0, '0, 0, 0);
    repeat (5) begin
      step();
      chk("stall_valid", o_valid, 1);
      chk("stall_ready", o_ready, 0);
      chk("stall_off", o_offset, {ACC_W'(2), ACC_W'(0)});
      chk("stall_beat", o_beat_len, 4);
    end
    i_ready = 1'b1;
    step();
    chk("release_valid", o_valid, 1);
    chk("release_off", o_offset, {ACC_W'(38), ACC_W'(4)});
    chk("release_line", o_line_len, 72);
    drive(0, '0, '0, '0, '0, '0, 0, 1);
    step();

    // Flush together with beat1 drops it and restarts offsets.
    drive(1, '0, '0, 2'b01, 2'b10, '0, 0, 1);
    step();
    chk("flush_b0_beat", o_beat_len, 28);
    drive(1, 2'b11, '0, '0, '0, '0, 1, 1);
    step();
    chk("flush_drop", o_valid, 0);
    drive(1, 2'b11, '0, '0, '0, '0, 0, 1);
    step();
    chk("flush_off", o_offset, {ACC_W'(2), ACC_W'(0)});
    chk("flush_end", o_line_end, 0);
    drive(0, '0, '0, '0, '0, '0, 0, 1);
    step();

    // Reset mid-line (one beat already accepted above).
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    drive(1, 2'b11, '0, '0, '0, '0, 0, 1);
    step();
    step();
    chk("rst_mid_end", o_line_end, 1);
    chk("rst_mid_line", o_line_len, 8);
    drive(0, '0, '0, '0, '0, '0, 0, 1);
    step();
    chk("rst_mid_stat", o_stat_lines, STATS ? 1 : 0);

    repeat (800) begin
      logic [L-1:0] r_zf, r_mf, r_zu, r_m3, r_m2;
      for (int k = 0; k < L; k++) begin
        r_zf[k] = ($urandom_range(3) == 0);
        r_mf[k] = ($urandom_range(3) == 0);
        r_zu[k] = ($urandom_range(3) == 0);
        r_m3[k] = ($urandom_range(3) == 0);
        r_m2[k] = ($urandom_range(3) == 0);
      end
      drive($urandom_range(3) != 0, r_zf, r_mf, r_zu, r_m3, r_m2,
            $urandom_range(15) == 0, $urandom_range(3) != 0);
      step();
    end
    drive(0, '0, '0, '0, '0, '0, 0, 1);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/length_generation_nlane.md
Name: length_generation_nlane

Overview:
- Parametrised successor to the two-word length generator in the compression pipeline.
- Classifies LANES words per beat into C-Pack codes and produces per-lane code lengths and per-lane bit offsets within the packed line.
- Accumulates the compressed length over each cache line and flags lines that do not compress.
- Sits between the pattern/dictionary matcher and the bit packer; valid/ready on both sides, one registered output stage.

Parameters:
- CACHE_LINE, 128, raw line size in bits.
- WORD_SIZE, 32, word size in bits.
- LANES, 2, words classified per beat; CACHE_LINE must be divisible by WORD_SIZE*LANES.
- DICT_IDX_W, 4, dictionary index width; must be ≤ WORD_SIZE/2-2.

Derived values:
- BEATS = CACHE_LINE/(WORD_SIZE*LANES).
- LEN_W = $clog2(WORD_SIZE+3).
- ACC_W = $clog2((CACHE_LINE/WORD_SIZE)*(WORD_SIZE+2)+1).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  reset: asynchronous, active-high.
- i_valid  in  1  input beat valid.
- o_ready  out  1  block can accept a beat.
- i_zero_full  in  LANES  lane word is all zero (ZZZZ).
- i_zero_upper  in  LANES  upper bytes zero, low byte nonzero (ZZZX).
- i_match_full  in  LANES  full dictionary match (MMMM).
- i_match_3b  in  LANES  upper 3 bytes match (MMMX).
- i_match_2b  in  LANES  upper half matches (MMXX).
- i_flush  in  1  synchronous abort of the partial line.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts.
- o_encoded  out  3*LANES  per-lane code id.
- o_length  out  LEN_W*LANES  per-lane code length in bits.
- o_offset  out  ACC_W*LANES  bit offset of each lane's code in the line.
- o_beat_len  out  ACC_W  sum of this beat's lengths.
- o_line_end  out  1  beat is the last of a line.
- o_line_len  out  ACC_W  total line length; valid when o_line_end.
- o_incompressible  out  1  o_line_len ≥ CACHE_LINE; valid when o_line_end.
- o_stat_lines  out  32  lines completed (LENGTH_STATS_EN only).
- o_stat_incomp  out  32  incompressible lines (LENGTH_STATS_EN only).

Behaviour:
- Lane classification (combinational), priority in the order listed:
  - zero_full: enc 0, len 2.
  - match_full: enc 1, len 2+DICT_IDX_W.
  - zero_upper: enc 2, len 12.
  - match_3b: enc 4, len 12+DICT_IDX_W.
  - match_2b: enc 3, len 4+DICT_IDX_W+WORD_SIZE/2.
  - none: enc 5, len 2+WORD_SIZE.
- Offsets: lane k offset = acc + sum of lengths of lanes 0..k-1. acc is the line bits accumulated before this beat. All arithmetic is ACC_W unsigned; no overflow is possible by construction.
- Handshake:
  - accept = i_valid & o_ready, where o_ready = !o_valid | i_ready.
  - Outputs register one cycle after accept (latency 1).
  - Outputs are held stable while o_valid & !i_ready.
  - Full throughput: one beat per cycle.
- Line state: beat counter cnt in 0..BEATS-1, plus acc.
  - On accept with cnt==BEATS-1: o_line_end=1, o_line_len=acc+beat_len; acc and cnt clear to 0.
  - On accept with cnt<BEATS-1: acc += beat_len, cnt++.
  - BEATS==1: every beat is a line end with offsets from 0.
- Flush:
  - i_flush clears acc and cnt next edge.
  - A beat accepted in the same cycle as i_flush is discarded and does not register to the output.
  - Flush does not affect an already-registered output beat.
- Reset:
  - All outputs 0; o_valid=0, o_ready=1 once reset is released.
  - acc=0, cnt=0, stats=0.
  - Reset mid-line discards the partial line.

Optional Feature:
- LENGTH_STATS_EN defined:
  - o_stat_lines increments on each output handshake with o_line_end.
  - o_stat_incomp also increments when o_incompressible is set.
  - Both counters saturate at 32'hFFFF_FFFF and are cleared by reset only.
- LENGTH_STATS_EN undefined: both stat outputs are tied to 0 and no counter flops exist.

Test Plan:
- Defaults; two beats, all lanes zero_full → lengths 2,2; offsets beat0 0,2, beat1 4,6; o_line_len=8; o_incompressible=0.
- Two beats, no flags → lengths 34; offsets 0,34,68,102; o_line_len=136; o_incompressible=1.
- One lane with both zero_full and match_full set → enc 0, len 2. One lane with match_2b only → enc 3, len 24.
- i_ready held low 5 cycles with o_valid=1 → outputs stable, o_ready=0, no beat lost; release → next beat follows the next cycle.
- Accept beat0 (len 12+16), then i_flush together with beat1 → beat1 dropped; next beat has offsets from 0 and o_line_end=0.
- Assert i_reset mid-line (after beat0), release, send 2 beats → o_line_len counts only post-reset beats. With LENGTH_STATS_EN, o_stat_lines=1 after the line.
